// File: rtl/mem_line_arbiter_if.sv
// Bundle of I-side, D-side and RAM-port signals for mem_line_arbiter.
// Latency: n/a (wires only). Backpressure: req_valid/req_ready per side; responses are unthrottled pulses.
// Modports: slave = arbiter view (takes requests, drives RAM port); master = requesters plus RAM.
interface mem_line_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_WIDTH = 128
);
  // I side (read-only)
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_resp_valid;
  logic [LINE_WIDTH-1:0] i_resp_data;
  // D side (read or write)
  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_req_we;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [LINE_WIDTH-1:0] d_req_wdata;
  logic                  d_resp_valid;
  logic [LINE_WIDTH-1:0] d_resp_data;
  // RAM read/write port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_din;
  logic                  mem_we;
  logic [LINE_WIDTH-1:0] mem_dout;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_addr, mem_din, mem_we,
    input  mem_dout
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_addr, mem_din, mem_we,
    output mem_dout
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sequencing I/D line requests onto one shared RAM port.
// Latency: accept-to-response MEM_LATENCY+1 cycles; one request per MEM_LATENCY+2 cycles.
// Backpressure: readies only high in IDLE for the arbitration winner; responses are one-cycle pulses.
// Ports: clk, rst_n (async, active-low), bus (mem_line_arbiter_if.slave: I/D handshakes, RAM port).
// Optional: define MEM_LINE_ARBITER_PERF_EN to add perf_i_grants/perf_d_grants/perf_conflicts.
module mem_line_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int LINE_WIDTH  = 128,
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MEM_LINE_ARBITER_PERF_EN
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflicts,
`endif
  mem_line_arbiter_if.slave bus
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  last_i;     // 1: last grant went to I, 0: to D
  logic                  own_i;      // owner of the in-flight request
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;
  logic                  mem_we_q;
  logic                  i_resp_q;
  logic                  d_resp_q;

  logic win_i;
  logic win_d;

  // On a conflict the side not granted last wins.
  assign win_i = bus.i_req_valid && (!bus.d_req_valid || !last_i);
  assign win_d = bus.d_req_valid && (!bus.i_req_valid ||  last_i);

  assign bus.i_req_ready  = (state == IDLE) && win_i;
  assign bus.d_req_ready  = (state == IDLE) && win_d;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_din      = wdata_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.i_resp_valid = i_resp_q;
  assign bus.d_resp_valid = d_resp_q;
  assign bus.i_resp_data  = i_rdata_q;
  assign bus.d_resp_data  = d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_i    <= 1'b0;
      own_i     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_we_q  <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_i) begin
            own_i    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= {bus.i_req_addr[ADDR_WIDTH-1:4], 4'b0000};
            wdata_q  <= '0;
            last_i   <= 1'b1;
            cnt      <= CNT_LOAD;
            mem_we_q <= 1'b0;
            state    <= ACCESS;
          end else if (win_d) begin
            own_i    <= 1'b0;
            we_q     <= bus.d_req_we;
            addr_q   <= {bus.d_req_addr[ADDR_WIDTH-1:4], 4'b0000};
            wdata_q  <= bus.d_req_wdata;
            last_i   <= 1'b0;
            cnt      <= CNT_LOAD;
            // With a one-cycle window the write strobe is due in the very next cycle.
            mem_we_q <= SINGLE_CYCLE && bus.d_req_we;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_we_q <= 1'b0;
            if (own_i) begin
              i_rdata_q <= bus.mem_dout;
              i_resp_q  <= 1'b1;
            end else begin
              d_rdata_q <= we_q ? wdata_q : bus.mem_dout;
              d_resp_q  <= 1'b1;
            end
            state <= RESPOND;
          end else begin
            cnt      <= cnt - 1'b1;
            // Raise the strobe for the final access cycle only.
            mem_we_q <= (cnt == CW'(1)) && we_q;
          end
        end
        RESPOND: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_LINE_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state == IDLE) begin
      if (win_i) perf_i_grants <= perf_i_grants + 32'd1;
      if (win_d) perf_d_grants <= perf_d_grants + 32'd1;
      if (bus.i_req_valid && bus.d_req_valid) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: directed I/D traffic on an L=2 instance with a transaction-level
// model checked every cycle, plus back-to-back reads on an L=1 instance.
module tb_mem_line_arbiter;
  localparam int AW = 17;
  localparam int LW = 128;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_line_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) b0 ();
  mem_line_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) b1 ();

`ifdef MEM_LINE_ARBITER_PERF_EN
  logic [31:0] p0_i, p0_d, p0_c, p1_i, p1_d, p1_c;
`endif

  mem_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LATENCY(L)) u0 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MEM_LINE_ARBITER_PERF_EN
    .perf_i_grants(p0_i),
    .perf_d_grants(p0_d),
    .perf_conflicts(p0_c),
`endif
    .bus(b0)
  );

  mem_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LATENCY(1)) u1 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MEM_LINE_ARBITER_PERF_EN
    .perf_i_grants(p1_i),
    .perf_d_grants(p1_d),
    .perf_conflicts(p1_c),
`endif
    .bus(b1)
  );

  function automatic logic [LW-1:0] init_line(input int k);
    if (k == 16) return 128'h00112233445566778899AABBCCDDEEFF;
    return {4{32'hC0DE0000 + 32'(k)}};
  endfunction

  // RAM behind instance 0: combinational read, write on the clock edge.
  logic [LW-1:0] ram [64];
  bit ram_loaded = 1'b0;
  assign b0.mem_dout = ram[b0.mem_addr[9:4]];
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 64; k++) ram[k] <= init_line(k);
      ram_loaded <= 1'b1;
    end else if (b0.mem_we) begin
      ram[b0.mem_addr[9:4]] <= b0.mem_din;
    end
  end

  // RAM behind instance 1 just reflects the address.
  assign b1.mem_dout = {{(LW-AW){1'b0}}, b1.mem_addr};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- transaction-level model of instance 0 ----------------
  logic [LW-1:0] ref_mem [64];
  bit            ref_loaded = 1'b0;
  int            cyc, acc_cyc, ph;
  bit            have_acc, last_i, own_i, m_we, idle, in_acc;
  bit            e_ir, e_dr, e_iv, e_dv;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wd, exp_ri, exp_rd, cap;

  always @(negedge clk) begin
    if (!ref_loaded) begin
      for (int k = 0; k < 64; k++) ref_mem[k] = init_line(k);
      ref_loaded = 1'b1;
    end
    if (!rst_n) begin
      have_acc = 1'b0; last_i = 1'b0; exp_ri = '0; exp_rd = '0; cyc = 0;
    end else begin
      cyc++;
      ph     = cyc - acc_cyc;
      idle   = !have_acc || (ph > L + 1);
      e_ir   = idle && b0.i_req_valid && (!b0.d_req_valid || !last_i);
      e_dr   = idle && b0.d_req_valid && (!b0.i_req_valid || last_i);
      in_acc = !idle && ph >= 1 && ph <= L;
      e_iv   = !idle && ph == L + 1 && own_i;
      e_dv   = !idle && ph == L + 1 && !own_i;
      chk("m_i_ready", b0.i_req_ready, e_ir);
      chk("m_d_ready", b0.d_req_ready, e_dr);
      chk("m_i_resp_valid", b0.i_resp_valid, e_iv);
      chk("m_d_resp_valid", b0.d_resp_valid, e_dv);
      chk("m_i_resp_data", b0.i_resp_data, exp_ri);
      chk("m_d_resp_data", b0.d_resp_data, exp_rd);
      chk("m_mem_we", b0.mem_we, in_acc && ph == L && m_we);
      if (in_acc) chk("m_mem_addr", b0.mem_addr, m_addr);
      if (in_acc && !own_i) chk("m_mem_din", b0.mem_din, m_wd);
      if (in_acc && ph == L) begin
        cap = m_we ? m_wd : ref_mem[m_addr[9:4]];
        if (m_we) ref_mem[m_addr[9:4]] = m_wd;
        if (own_i) exp_ri = cap; else exp_rd = cap;
      end
      if (e_ir) begin
        have_acc = 1'b1; acc_cyc = cyc; own_i = 1'b1; m_we = 1'b0; last_i = 1'b1;
        m_addr = b0.i_req_addr & ~AW'(15);
      end else if (e_dr) begin
        have_acc = 1'b1; acc_cyc = cyc; own_i = 1'b0; m_we = b0.d_req_we; last_i = 1'b0;
        m_addr = b0.d_req_addr & ~AW'(15); m_wd = b0.d_req_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic sample();
    @(negedge clk); #1;
  endtask

  localparam logic [LW-1:0] LINE100 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [LW-1:0] A5      = {16{8'hA5}};
  localparam logic [LW-1:0] X5A     = {16{8'h5A}};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t [4];
    int ng;
    int t_now;
    logic [3:0] ord;

    b0.i_req_valid = 0; b0.i_req_addr = '0; b0.d_req_valid = 0; b0.d_req_we = 0;
    b0.d_req_addr = '0; b0.d_req_wdata = '0;
    b1.i_req_valid = 0; b1.i_req_addr = '0; b1.d_req_valid = 0; b1.d_req_we = 0;
    b1.d_req_addr = '0; b1.d_req_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", b0.mem_we, 0);
    chk("rst_mem_addr", b0.mem_addr, 0);
    chk("rst_mem_din", b0.mem_din, 0);
    chk("rst_i_resp_valid", b0.i_resp_valid, 0);
    chk("rst_d_resp_data", b0.d_resp_data, 0);
    chk("rst_ready", {b0.i_req_ready, b0.d_req_ready}, 0);
    rst_n = 1'b1;

    // I read at 0x100
    b0.i_req_valid = 1; b0.i_req_addr = 17'h100;
    sample(); chk("i_rd_accept", b0.i_req_ready, 1);
    step(); b0.i_req_valid = 0;
    sample(); chk("i_rd_addr_c1", b0.mem_addr, 17'h100);
    step(); sample(); chk("i_rd_addr_c2", b0.mem_addr, 17'h100);
    step(); sample();
    chk("i_rd_valid_c3", b0.i_resp_valid, 1);
    chk("i_rd_data", b0.i_resp_data, LINE100);
    chk("i_rd_dvalid_c3", b0.d_resp_valid, 0);
    step(); sample(); chk("i_rd_valid_c4", b0.i_resp_valid, 0);

    // D write 0x200 then read back
    step();
    b0.d_req_valid = 1; b0.d_req_we = 1; b0.d_req_addr = 17'h200; b0.d_req_wdata = A5;
    sample(); chk("d_wr_accept", b0.d_req_ready, 1);
    step(); b0.d_req_valid = 0;
    sample(); chk("d_wr_we_c1", b0.mem_we, 0);
    step(); sample(); chk("d_wr_we_c2", b0.mem_we, 1);
    step(); sample();
    chk("d_wr_ack", b0.d_resp_valid, 1);
    chk("d_wr_ack_data", b0.d_resp_data, A5);
    step();
    b0.d_req_we = 0; b0.d_req_valid = 1;
    sample(); chk("d_rd_accept", b0.d_req_ready, 1);
    step(); b0.d_req_valid = 0;
    step(); step(); sample();
    chk("d_rd_valid", b0.d_resp_valid, 1);
    chk("d_rd_data", b0.d_resp_data, A5);

    // Unaligned I address
    step();
    b0.i_req_valid = 1; b0.i_req_addr = 17'h10B;
    sample();
    step(); b0.i_req_valid = 0;
    sample(); chk("unaligned_addr", b0.mem_addr, 17'h100);
    step(); step(); sample(); chk("unaligned_data", b0.i_resp_data, LINE100);

    // Reset in the middle of a write window
    step();
    b0.d_req_valid = 1; b0.d_req_we = 1; b0.d_req_addr = 17'h200; b0.d_req_wdata = X5A;
    sample(); chk("midrst_accept", b0.d_req_ready, 1);
    step(); b0.d_req_valid = 0; b0.d_req_we = 0;
    sample();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", b0.mem_we, 0);
    chk("midrst_mem_addr", b0.mem_addr, 0);
    chk("midrst_resp_valid", {b0.i_resp_valid, b0.d_resp_valid}, 0);
    chk("midrst_d_resp_data", b0.d_resp_data, 0);
    step(); step();
    chk("midrst_ram_kept", ram[32], A5);

    // Conflict from reset: both sides valid continuously
    rst_n = 1'b1;
    b0.i_req_valid = 1; b0.i_req_addr = 17'h300;
    b0.d_req_valid = 1; b0.d_req_addr = 17'h340;
    ng = 0; ord = '0; t_now = 0;
    while (ng < 4 && t_now < 40) begin
      sample();
      if (b0.i_req_ready) begin ord = {ord[2:0], 1'b1}; t[ng] = t_now; ng++; end
      else if (b0.d_req_ready) begin ord = {ord[2:0], 1'b0}; t[ng] = t_now; ng++; end
      step();
      t_now++;
    end
    chk("conflict_grants", ng, 4);
    chk("conflict_order", ord, 4'b1010);
    for (int k = 0; k < 3; k++) chk("conflict_spacing", t[k+1] - t[k], L + 2);
`ifdef MEM_LINE_ARBITER_PERF_EN
    chk("perf_conflicts", p0_c, 4);
    chk("perf_i_grants", p0_i, 2);
`endif
    b0.i_req_valid = 0; b0.d_req_valid = 0;
    repeat (6) step();

    // MEM_LATENCY=1 instance: back-to-back D reads
    b1.d_req_valid = 1; b1.d_req_we = 0; b1.d_req_addr = 17'h400;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("l1_ready", b1.d_req_ready, (k % 3) == 0);
      chk("l1_resp_valid", b1.d_resp_valid, (k % 3) == 2);
      if (k % 3 == 2) chk("l1_resp_data", b1.d_resp_data, 128'h400);
      step();
    end
    b1.d_req_valid = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
